// File: rtl/multicycle_controller.sv
`default_nettype none
// =============================================================================
// multicycle_controller : control FSM sequencing a shared multicycle RV32I datapath
// Revision 1.0
// =============================================================================
module multicycle_controller #(
    parameter int INSTRET_W   = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 Zero,
    input  logic                 Lt,
    input  logic                 LtU,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ALUOp,
    output logic [2:0]           ImmSrc,
    output logic [INSTRET_W-1:0] instret,
    output logic                 trap,
    output logic [1:0]           trap_cause
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_NOP    = 7'b0000000;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_BRANCH  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRWB, S_LUI, S_TRAP
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [INSTRET_W-1:0]   instret_q, instret_d;
    logic [1:0]             cause_q, cause_d;

    logic w_wait_state;
    logic w_timeout;
    logic w_taken;

    assign w_wait_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    assign w_timeout    = (MEM_TIMEOUT != 0) && w_wait_state && (cnt_q == TIMEOUT_VAL);

    always_comb begin
        case (funct3)
            3'b000:  w_taken = Zero;
            3'b001:  w_taken = !Zero;
            3'b100:  w_taken = Lt;
            3'b101:  w_taken = !Lt;
            3'b110:  w_taken = LtU;
            3'b111:  w_taken = !LtU;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        if (w_timeout) begin
            state_d = S_TRAP;
            cause_d = CAUSE_TIMEOUT;
        end else begin
            case (state_q)
                S_FETCH:    if (mem_ready) state_d = S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LOAD, OP_STORE: state_d = S_MEMADR;
                        OP_R:              state_d = S_EXECR;
                        OP_I:              state_d = S_EXECI;
                        OP_BRANCH: begin
                            if (funct3 == 3'b010 || funct3 == 3'b011) begin
                                state_d = S_TRAP;
                                cause_d = CAUSE_BRANCH;
                            end else begin
                                state_d = S_BRANCH;
                            end
                        end
                        OP_JAL:            state_d = S_JAL;
                        OP_JALR:           state_d = S_JALR;
                        OP_LUI:            state_d = S_LUI;
                        // ALUOut already holds OldPC+imm from this cycle
                        OP_AUIPC:          state_d = S_ALUWB;
                        OP_NOP:            state_d = S_FETCH;
                        default: begin
                            state_d = S_TRAP;
                            cause_d = CAUSE_ILLEGAL;
                        end
                    endcase
                end
                S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
                S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
                S_MEMWB, S_ALUWB, S_BRANCH, S_JALRWB: state_d = S_FETCH;
                S_EXECR, S_EXECI, S_JAL, S_LUI:       state_d = S_ALUWB;
                S_JALR:     state_d = S_JALRWB;
                S_TRAP:     state_d = S_TRAP;
                default:    state_d = S_FETCH;
            endcase
        end

        // Wait count only survives cycles that stay in the same waiting state
        cnt_d = '0;
        if (w_wait_state && !mem_ready && (state_d == state_q)) cnt_d = cnt_q + 1'b1;

        instret_d = instret_q;
        if ((state_d == S_FETCH) && (state_q != S_FETCH)) instret_d = instret_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            instret_q <= '0;
            cause_q   <= CAUSE_NONE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            instret_q <= instret_d;
            cause_q   <= cause_d;
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
            S_MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
            S_MEMREAD:  begin mem_req = 1'b1; AdrSrc = 1'b1; end
            S_MEMWB:    begin ResultSrc = 2'b01; RegWrite = 1'b1; end
            S_MEMWRITE: begin mem_req = 1'b1; AdrSrc = 1'b1; MemWrite = 1'b1; end
            S_EXECR:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b00; ALUOp = 2'b10; end
            S_EXECI:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUOp = 2'b10; end
            S_ALUWB:    RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                PCWrite = w_taken;
            end
            S_JAL:      begin PCWrite = 1'b1; ALUSrcA = 2'b01; ALUSrcB = 2'b10; end
            S_JALR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
            end
            S_JALRWB: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                RegWrite  = 1'b1;
            end
            S_LUI:      begin ALUSrcA = 2'b11; ALUSrcB = 2'b01; end
            default: ;
        endcase
        // Strobes are suppressed during reset and in the cycle a timeout fires
        if (!reset_n || w_timeout) begin
            mem_req  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
        end
    end

    always_comb begin
        case (op)
            OP_STORE:         ImmSrc = 3'b001;
            OP_BRANCH:        ImmSrc = 3'b010;
            OP_JAL:           ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
            default:          ImmSrc = 3'b000;
        endcase
    end

    assign instret    = instret_q;
    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// =============================================================================
// tb_multicycle_controller : random instruction stream checked against a
// cycle/strobe-count reference model, plus directed boundary scenarios
// Revision 1.0
// =============================================================================
module tb_multicycle_controller;
    localparam int INSTRET_W   = 4;
    localparam int MEM_TIMEOUT = 4;
    localparam int MAXC        = 64;
    localparam int NEVER       = 100000;

    localparam logic [6:0] OP_LOAD  = 7'b0000011, OP_STORE = 7'b0100011, OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011, OP_BR    = 7'b1100011, OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111, OP_LUI   = 7'b0110111, OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_NOP   = 7'b0000000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic Zero = 1'b0, Lt = 1'b0, LtU = 1'b0, mem_ready = 1'b0;
    logic mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, trap;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, trap_cause;
    logic [2:0] ImmSrc;
    logic [INSTRET_W-1:0] instret;

    int n_checks = 0;
    int n_fail = 0;
    int exp_instret = 0;
    int waits[$];
    int c_memreq, c_irw, c_pcw, c_regw, c_memw, bad_imm;
    logic       tr_irw[MAXC];
    logic       tr_pcw[MAXC];
    logic       tr_regw[MAXC];
    logic [1:0] tr_rsrc[MAXC];
    logic [1:0] tr_asa[MAXC];
    logic [1:0] tr_asb[MAXC];
    logic [1:0] tr_aluop[MAXC];

    typedef struct packed {
        int cycles; int irw; int pcw; int regw; int memw; int memreq; logic [2:0] imm;
    } exp_t;

    multicycle_controller #(.INSTRET_W(INSTRET_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .Zero(Zero), .Lt(Lt),
        .LtU(LtU), .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .ImmSrc(ImmSrc), .instret(instret), .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    function automatic logic br_taken(input logic [2:0] f3, input logic z, input logic lt, input logic ltu);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return lt;
            3'd5: return !lt;
            3'd6: return ltu;
            3'd7: return !ltu;
            default: return 1'b0;
        endcase
    endfunction

    // Instruction-level cost model: cycles and strobe totals for one legal instruction
    function automatic exp_t model(input logic [6:0] o, input logic [2:0] f3, input logic z,
                                   input logic lt, input logic ltu, input int w0, input int w1);
        exp_t e;
        e.cycles = w0 + 2; e.irw = 1; e.pcw = 1; e.regw = 0; e.memw = 0; e.memreq = w0 + 1; e.imm = 3'd0;
        case (o)
            OP_LOAD:  begin e.cycles += w1 + 3; e.memreq += w1 + 1; e.regw = 1; end
            OP_STORE: begin e.cycles += w1 + 2; e.memreq += w1 + 1; e.memw = w1 + 1; e.imm = 3'd1; end
            OP_R, OP_I: begin e.cycles += 2; e.regw = 1; end
            OP_LUI:   begin e.cycles += 2; e.regw = 1; e.imm = 3'd4; end
            OP_AUIPC: begin e.cycles += 1; e.regw = 1; e.imm = 3'd4; end
            OP_JAL:   begin e.cycles += 2; e.pcw += 1; e.regw = 1; e.imm = 3'd3; end
            OP_JALR:  begin e.cycles += 2; e.pcw += 1; e.regw = 1; end
            OP_BR:    begin e.cycles += 1; e.pcw += br_taken(f3, z, lt, ltu) ? 1 : 0; e.imm = 3'd2; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic set_waits(input int a, input int b);
        waits.delete();
        waits.push_back(a);
        waits.push_back(b);
    endtask

    // Runs n cycles from just after a negedge; memory answers each request after its wait count
    task automatic run_cycles(input int n, input logic [2:0] exp_imm);
        int wleft;
        c_memreq = 0; c_irw = 0; c_pcw = 0; c_regw = 0; c_memw = 0; bad_imm = 0;
        wleft = (waits.size() > 0) ? waits.pop_front() : NEVER;
        for (int i = 0; i < n; i++) begin
            mem_ready = 1'b0;
            #1;
            if (mem_req === 1'b1) begin
                if (wleft == 0) begin
                    mem_ready = 1'b1;
                    wleft = (waits.size() > 0) ? waits.pop_front() : NEVER;
                end else begin
                    wleft--;
                end
            end
            #1;
            c_memreq += (mem_req === 1'b1) ? 1 : 0;
            c_irw    += (IRWrite === 1'b1) ? 1 : 0;
            c_pcw    += (PCWrite === 1'b1) ? 1 : 0;
            c_regw   += (RegWrite === 1'b1) ? 1 : 0;
            c_memw   += (MemWrite === 1'b1) ? 1 : 0;
            if (ImmSrc !== exp_imm) bad_imm++;
            if (i < MAXC) begin
                tr_irw[i] = IRWrite; tr_pcw[i] = PCWrite; tr_regw[i] = RegWrite;
                tr_rsrc[i] = ResultSrc; tr_asa[i] = ALUSrcA; tr_asb[i] = ALUSrcB; tr_aluop[i] = ALUOp;
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if ({mem_req, MemWrite, IRWrite, PCWrite, RegWrite} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b expected 00000", {mem_req, MemWrite, IRWrite, PCWrite, RegWrite});
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (trap !== 1'b0 || trap_cause !== 2'b00 || instret !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got trap=%b cause=%b instret=%0d expected 0/00/0", trap, trap_cause, instret);
        end
        reset_n = 1'b1;
        exp_instret = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_lw();
        exp_t e;
        op = OP_LOAD; funct3 = 3'b010;
        set_waits(0, 0);
        e = model(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 0, 0);
        run_cycles(e.cycles, e.imm);
        exp_instret = (exp_instret + 1) % (1 << INSTRET_W);
        n_checks++;
        if (c_regw !== 1 || tr_regw[4] !== 1'b1) begin
            n_fail++; $display("FAIL lw_regwrite: got count=%0d last=%b expected 1/1", c_regw, tr_regw[4]);
        end
        n_checks++;
        if (tr_rsrc[4] !== 2'b01) begin n_fail++; $display("FAIL lw_resultsrc: got %b expected 01", tr_rsrc[4]); end
        n_checks++;
        if (instret !== INSTRET_W'(exp_instret)) begin
            n_fail++; $display("FAIL lw_instret: got %0d expected %0d", instret, exp_instret);
        end
    endtask

    task automatic test_add_wait();
        op = OP_R; funct3 = 3'b000;
        set_waits(3, 0);
        run_cycles(7, 3'd0);
        exp_instret = (exp_instret + 1) % (1 << INSTRET_W);
        n_checks++;
        if (c_irw !== 1 || tr_irw[3] !== 1'b1 || c_pcw !== 1 || tr_pcw[3] !== 1'b1) begin
            n_fail++; $display("FAIL add_fetch_pulse: got irw=%0d pcw=%0d at3=%b%b expected 1 1 11", c_irw, c_pcw, tr_irw[3], tr_pcw[3]);
        end
        n_checks++;
        if (tr_aluop[5] !== 2'b10 || tr_asa[5] !== 2'b10 || tr_asb[5] !== 2'b00) begin
            n_fail++; $display("FAIL add_execr: got op=%b a=%b b=%b expected 10 10 00", tr_aluop[5], tr_asa[5], tr_asb[5]);
        end
        n_checks++;
        if (tr_regw[6] !== 1'b1 || instret !== INSTRET_W'(exp_instret)) begin
            n_fail++; $display("FAIL add_aluwb: got regw=%b instret=%0d expected 1 %0d", tr_regw[6], instret, exp_instret);
        end
    endtask

    task automatic test_branch();
        op = OP_BR; funct3 = 3'b000; Zero = 1'b1;
        set_waits(0, 0);
        run_cycles(3, 3'd2);
        n_checks++;
        if (tr_pcw[2] !== 1'b1 || tr_aluop[2] !== 2'b01) begin
            n_fail++; $display("FAIL beq_taken: got pcw=%b aluop=%b expected 1 01", tr_pcw[2], tr_aluop[2]);
        end
        funct3 = 3'b001;
        set_waits(0, 0);
        run_cycles(3, 3'd2);
        exp_instret = (exp_instret + 2) % (1 << INSTRET_W);
        n_checks++;
        if (tr_pcw[2] !== 1'b0 || c_pcw !== 1) begin
            n_fail++; $display("FAIL bne_not_taken: got pcw=%b count=%0d expected 0 1", tr_pcw[2], c_pcw);
        end
        n_checks++;
        if (instret !== INSTRET_W'(exp_instret)) begin
            n_fail++; $display("FAIL branch_instret: got %0d expected %0d", instret, exp_instret);
        end
        Zero = 1'b0;
    endtask

    task automatic test_jalr();
        op = OP_JALR; funct3 = 3'b000;
        set_waits(0, 0);
        run_cycles(4, 3'd0);
        exp_instret = (exp_instret + 1) % (1 << INSTRET_W);
        n_checks++;
        if (tr_pcw[2] !== 1'b1 || tr_rsrc[2] !== 2'b10) begin
            n_fail++; $display("FAIL jalr_pc: got pcw=%b rsrc=%b expected 1 10", tr_pcw[2], tr_rsrc[2]);
        end
        n_checks++;
        if (tr_regw[3] !== 1'b1 || tr_asa[3] !== 2'b01 || tr_asb[3] !== 2'b10 || c_regw !== 1) begin
            n_fail++; $display("FAIL jalr_wb: got regw=%b a=%b b=%b n=%0d expected 1 01 10 1", tr_regw[3], tr_asa[3], tr_asb[3], c_regw);
        end
        n_checks++;
        if (instret !== INSTRET_W'(exp_instret)) begin
            n_fail++; $display("FAIL jalr_instret: got %0d expected %0d", instret, exp_instret);
        end
    endtask

    task automatic test_illegal();
        op = 7'b1111111; funct3 = 3'b000;
        set_waits(1, 0);
        run_cycles(6, 3'd0);
        n_checks++;
        if (trap !== 1'b1 || trap_cause !== 2'b01) begin
            n_fail++; $display("FAIL illegal_op_trap: got trap=%b cause=%b expected 1 01", trap, trap_cause);
        end
        n_checks++;
        if (c_memreq !== 2 || c_irw !== 1 || c_pcw !== 1 || c_regw !== 0 || c_memw !== 0) begin
            n_fail++; $display("FAIL illegal_op_strobes: got req=%0d irw=%0d pcw=%0d regw=%0d memw=%0d expected 2 1 1 0 0", c_memreq, c_irw, c_pcw, c_regw, c_memw);
        end
        n_checks++;
        if (instret !== INSTRET_W'(exp_instret)) begin
            n_fail++; $display("FAIL illegal_op_instret: got %0d expected %0d", instret, exp_instret);
        end
        do_reset();
        op = OP_BR; funct3 = 3'b011;
        set_waits(0, 0);
        run_cycles(5, 3'd2);
        n_checks++;
        if (trap !== 1'b1 || trap_cause !== 2'b10 || c_pcw !== 1) begin
            n_fail++; $display("FAIL illegal_branch_trap: got trap=%b cause=%b pcw=%0d expected 1 10 1", trap, trap_cause, c_pcw);
        end
        do_reset();
    endtask

    task automatic test_timeout();
        op = OP_STORE; funct3 = 3'b010;
        set_waits(0, MEM_TIMEOUT - 1);
        run_cycles(7, 3'd1);
        exp_instret = (exp_instret + 1) % (1 << INSTRET_W);
        n_checks++;
        if (trap !== 1'b0 || c_memw !== MEM_TIMEOUT || instret !== INSTRET_W'(exp_instret)) begin
            n_fail++; $display("FAIL sw_wait_limit: got trap=%b memw=%0d instret=%0d expected 0 %0d %0d", trap, c_memw, instret, MEM_TIMEOUT, exp_instret);
        end
        waits.delete();
        waits.push_back(0);
        run_cycles(10, 3'd1);
        n_checks++;
        if (trap !== 1'b1 || trap_cause !== 2'b11) begin
            n_fail++; $display("FAIL sw_timeout_trap: got trap=%b cause=%b expected 1 11", trap, trap_cause);
        end
        n_checks++;
        if (c_memw !== MEM_TIMEOUT || c_memreq !== MEM_TIMEOUT + 1 || c_regw !== 0) begin
            n_fail++; $display("FAIL sw_timeout_strobes: got memw=%0d req=%0d regw=%0d expected %0d %0d 0", c_memw, c_memreq, c_regw, MEM_TIMEOUT, MEM_TIMEOUT + 1);
        end
        n_checks++;
        if (instret !== INSTRET_W'(exp_instret)) begin
            n_fail++; $display("FAIL sw_timeout_instret: got %0d expected %0d", instret, exp_instret);
        end
        do_reset();
        op = OP_R;
        waits.delete();
        run_cycles(7, 3'd0);
        n_checks++;
        if (trap !== 1'b1 || trap_cause !== 2'b11 || c_memreq !== MEM_TIMEOUT || c_irw !== 0) begin
            n_fail++; $display("FAIL fetch_timeout: got trap=%b cause=%b req=%0d irw=%0d expected 1 11 %0d 0", trap, trap_cause, c_memreq, c_irw, MEM_TIMEOUT);
        end
        do_reset();
    endtask

    task automatic test_mid_reset();
        op = OP_LOAD; funct3 = 3'b010;
        set_waits(1, NEVER);
        run_cycles(5, 3'd0);
        n_checks++;
        if (c_regw !== 0 || instret !== '0) begin
            n_fail++; $display("FAIL mid_reset_before: got regw=%0d instret=%0d expected 0 0", c_regw, instret);
        end
        do_reset();
        op = OP_NOP;
        set_waits(0, 0);
        run_cycles(2, 3'd0);
        exp_instret = 1;
        n_checks++;
        if (instret !== INSTRET_W'(exp_instret) || c_irw !== 1 || c_regw !== 0) begin
            n_fail++; $display("FAIL mid_reset_after: got instret=%0d irw=%0d regw=%0d expected 1 1 0", instret, c_irw, c_regw);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            logic [6:0] o;
            logic [2:0] f;
            int w0, w1;
            exp_t e;
            case ($urandom_range(0, 9))
                0: o = OP_LOAD;  1: o = OP_STORE; 2: o = OP_R;   3: o = OP_I;     4: o = OP_BR;
                5: o = OP_JAL;   6: o = OP_JALR;  7: o = OP_LUI; 8: o = OP_AUIPC; default: o = OP_NOP;
            endcase
            f = 3'($urandom_range(0, 7));
            if (o == OP_BR && (f == 3'd2 || f == 3'd3)) f = f + 3'd2;
            op = o; funct3 = f;
            Zero = 1'($urandom_range(0, 1)); Lt = 1'($urandom_range(0, 1)); LtU = 1'($urandom_range(0, 1));
            w0 = $urandom_range(0, MEM_TIMEOUT - 1);
            w1 = $urandom_range(0, MEM_TIMEOUT - 1);
            set_waits(w0, w1);
            e = model(o, f, Zero, Lt, LtU, w0, w1);
            run_cycles(e.cycles, e.imm);
            exp_instret = (exp_instret + 1) % (1 << INSTRET_W);
            n_checks++;
            if (instret !== INSTRET_W'(exp_instret)) begin
                n_fail++; $display("FAIL rnd%0d_instret op=%b: got %0d expected %0d", k, o, instret, exp_instret);
            end
            n_checks++;
            if (c_irw !== e.irw) begin n_fail++; $display("FAIL rnd%0d_irwrite op=%b: got %0d expected %0d", k, o, c_irw, e.irw); end
            n_checks++;
            if (c_pcw !== e.pcw) begin n_fail++; $display("FAIL rnd%0d_pcwrite op=%b f3=%b: got %0d expected %0d", k, o, f, c_pcw, e.pcw); end
            n_checks++;
            if (c_regw !== e.regw) begin n_fail++; $display("FAIL rnd%0d_regwrite op=%b: got %0d expected %0d", k, o, c_regw, e.regw); end
            n_checks++;
            if (c_memw !== e.memw) begin n_fail++; $display("FAIL rnd%0d_memwrite op=%b: got %0d expected %0d", k, o, c_memw, e.memw); end
            n_checks++;
            if (c_memreq !== e.memreq) begin n_fail++; $display("FAIL rnd%0d_memreq op=%b: got %0d expected %0d", k, o, c_memreq, e.memreq); end
            n_checks++;
            if (bad_imm !== 0) begin n_fail++; $display("FAIL rnd%0d_immsrc op=%b: got %0d bad cycles expected 0", k, o, bad_imm); end
            n_checks++;
            if (trap !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_trap op=%b: got %b expected 0", k, o, trap); end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_add_wait();
        test_branch();
        test_jalr();
        test_illegal();
        test_timeout();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
